// File: rtl/mux_uart.sv
// mux_uart: memory-mapped 8N1 serial port at the MUX 0 status/data addresses.
// Status at BASE: {4'b0, FRAMING_ERR, OVERRUN, TX_READY, RX_FULL}; data at BASE+1.
// TX is a two-byte queue (holding + shift register); RX is a single receive register.
module mux_uart #(
  parameter logic [15:0] BASE         = 16'hF200,
  parameter int          CLKS_PER_BIT = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] address,
  input  logic        write_en,
  input  logic        read_en,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        cs,
  input  logic        rxd,
  output logic        txd
);

  localparam int              CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]   CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   CNT_MID   = CW'(CLKS_PER_BIT / 2);
  localparam logic [15:0]     DATA_ADDR = BASE + 16'd1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  // ---------------- bus decode ----------------
  logic w_sel_stat;
  logic w_sel_data;
  logic w_tx_wr;
  logic w_stat_wr;
  logic w_rx_rd;
  logic [7:0] w_status;

  // TX state
  state_t        r_tx_state;
  logic [CW-1:0] r_tx_cnt;
  logic [2:0]    r_tx_bit;
  logic [7:0]    r_tx_shift;
  logic [7:0]    r_hold;
  logic          r_hold_full;
  logic          r_txd;

  // RX state
  logic [1:0]    r_rxd_sync;
  logic          w_rxd_s;
  state_t        r_rx_state;
  logic [CW-1:0] r_rx_cnt;
  logic [2:0]    r_rx_bit;
  logic [7:0]    r_rx_shift;
  logic          r_rx_armed;
  logic [7:0]    r_rx_data;
  logic          r_rx_full;
  logic          r_ovr;
  logic          r_ferr;

  assign w_sel_stat = (address == BASE);
  assign w_sel_data = (address == DATA_ADDR);
  assign cs         = w_sel_stat | w_sel_data;
  // Writes to the data register only land while the holding register is empty.
  assign w_tx_wr    = write_en & w_sel_data & ~r_hold_full;
  assign w_stat_wr  = write_en & w_sel_stat;
  assign w_rx_rd    = read_en & w_sel_data;
  assign w_status   = {4'b0000, r_ferr, r_ovr, ~r_hold_full, r_rx_full};
  assign w_rxd_s    = r_rxd_sync[1];
  assign txd        = r_txd;

  // Combinational read mux: status, receive data, or zero off-map.
  always_comb begin
    data_out = 8'h00;
    if (w_sel_stat)      data_out = w_status;
    else if (w_sel_data) data_out = r_rx_data;
  end

  // TX FSM: holding register fill from the bus, shift-out LSB first, back-to-back frames.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_state  <= ST_IDLE;
      r_tx_cnt    <= '0;
      r_tx_bit    <= 3'd0;
      r_tx_shift  <= 8'h00;
      r_hold      <= 8'h00;
      r_hold_full <= 1'b0;
      r_txd       <= 1'b1;
    end else begin
      // Bus fill and FSM drain never coincide: one needs the holding register empty, the other full.
      if (w_tx_wr) begin
        r_hold      <= data_in;
        r_hold_full <= 1'b1;
      end
      case (r_tx_state)
        ST_IDLE: begin
          if (r_hold_full) begin
            r_tx_shift  <= r_hold;
            r_hold_full <= 1'b0;
            r_txd       <= 1'b0;
            r_tx_cnt    <= '0;
            r_tx_state  <= ST_START;
          end
        end
        ST_START: begin
          if (r_tx_cnt == CNT_LAST) begin
            r_tx_cnt   <= '0;
            r_txd      <= r_tx_shift[0];
            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
            r_tx_bit   <= 3'd0;
            r_tx_state <= ST_DATA;
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (r_tx_cnt == CNT_LAST) begin
            r_tx_cnt <= '0;
            if (r_tx_bit == 3'd7) begin
              r_txd      <= 1'b1;
              r_tx_state <= ST_STOP;
            end else begin
              r_txd      <= r_tx_shift[0];
              r_tx_shift <= {1'b0, r_tx_shift[7:1]};
              r_tx_bit   <= r_tx_bit + 3'd1;
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (r_tx_cnt == CNT_LAST) begin
            r_tx_cnt <= '0;
            // A queued byte starts immediately after the stop bit, no idle gap.
            if (r_hold_full) begin
              r_tx_shift  <= r_hold;
              r_hold_full <= 1'b0;
              r_txd       <= 1'b0;
              r_tx_state  <= ST_START;
            end else begin
              r_tx_state <= ST_IDLE;
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        default: begin
          r_tx_state <= ST_IDLE;
          r_txd      <= 1'b1;
        end
      endcase
    end
  end

  // Two-flop synchronizer for the asynchronous serial input (idle high).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_rxd_sync <= 2'b11;
    else          r_rxd_sync <= {r_rxd_sync[0], rxd};
  end

  // RX FSM plus status flags; later assignments in this block win, so flag sets beat clears.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_state <= ST_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= 3'd0;
      r_rx_shift <= 8'h00;
      r_rx_armed <= 1'b0;
      r_rx_data  <= 8'h00;
      r_rx_full  <= 1'b0;
      r_ovr      <= 1'b0;
      r_ferr     <= 1'b0;
    end else begin
      if (w_rx_rd) r_rx_full <= 1'b0;
      if (w_stat_wr) begin
        r_ovr  <= 1'b0;
        r_ferr <= 1'b0;
      end
      case (r_rx_state)
        ST_IDLE: begin
          // After a frame the line must be seen high before another start is accepted.
          if (!r_rx_armed) begin
            if (w_rxd_s) r_rx_armed <= 1'b1;
          end else if (!w_rxd_s) begin
            r_rx_cnt   <= '0;
            r_rx_state <= ST_START;
          end
        end
        ST_START: begin
          if (r_rx_cnt == CNT_MID) begin
            if (w_rxd_s) begin
              // Line back high at mid-start: glitch, not a frame.
              r_rx_state <= ST_IDLE;
            end else begin
              r_rx_cnt   <= '0;
              r_rx_bit   <= 3'd0;
              r_rx_state <= ST_DATA;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (r_rx_cnt == CNT_LAST) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {w_rxd_s, r_rx_shift[7:1]};
            if (r_rx_bit == 3'd7) r_rx_state <= ST_STOP;
            else                  r_rx_bit   <= r_rx_bit + 3'd1;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (r_rx_cnt == CNT_LAST) begin
            r_rx_cnt   <= '0;
            r_rx_armed <= 1'b0;
            r_rx_state <= ST_IDLE;
            if (w_rxd_s) begin
              // A same-edge read frees the register, so the new byte loads cleanly.
              if (!r_rx_full || w_rx_rd) begin
                r_rx_data <= r_rx_shift;
                r_rx_full <= 1'b1;
              end else begin
                r_ovr <= 1'b1;
              end
            end else begin
              r_ferr <= 1'b1;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        default: r_rx_state <= ST_IDLE;
      endcase
    end
  end

endmodule
